// File: rtl/zzecc_sctag_cor_pipe.sv
// Two-stage SEC-DED check/correct pipeline for 32b data with the 7b sctag Hamming code.
// Stage 1 holds the raw codeword; stage 2 holds the classified, corrected result plus counters and log.
module zzecc_sctag_cor_pipe (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_data,
  input  logic [6:0]  in_par,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic        out_ce,
  output logic        out_ue,
  output logic [5:0]  out_syn,
  input  logic        cnt_clr,
  output logic [7:0]  ce_cnt,
  output logic [7:0]  ue_cnt,
  output logic        log_vld,
  output logic        log_ue,
  output logic [5:0]  log_syn
);

  function automatic logic is_pow2(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  // Data bits occupy every non-power-of-two position 3..38 in ascending order.
  function automatic logic [5:0] calc_syn(input logic [31:0] d, input logic [5:0] p);
    logic [5:0] s;
    logic [5:0] pos;
    logic [4:0] j;
    s = p;
    j = 5'd0;
    for (int q = 1; q <= 38; q++) begin
      pos = q[5:0];
      if (!is_pow2(pos)) begin
        s = s ^ ({6{d[j]}} & pos);
        j = j + 5'd1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] flip_at(input logic [31:0] d, input logic [5:0] syn);
    logic [31:0] r;
    logic [5:0]  pos;
    logic [4:0]  j;
    r = d;
    j = 5'd0;
    for (int q = 1; q <= 38; q++) begin
      pos = q[5:0];
      if (!is_pow2(pos)) begin
        if (pos == syn) r[j] = ~r[j];
        j = j + 5'd1;
      end
    end
    return r;
  endfunction

  logic        s1_vld_r, s2_vld_r;
  logic [31:0] s1_data_r, s2_data_r;
  logic [6:0]  s1_par_r;
  logic        s2_ce_r, s2_ue_r;
  logic [5:0]  s2_syn_r;
  logic [7:0]  ce_cnt_r, ue_cnt_r;
  logic        log_vld_r, log_ue_r;
  logic [5:0]  log_syn_r;

  logic        s2_adv_s, accept_s, deliver_s, ovr_s, ce_s, ue_s;
  logic [5:0]  syn_s;
  logic [31:0] cor_data_s;

  assign s2_adv_s  = !s2_vld_r || out_rdy;
  assign in_rdy    = !s1_vld_r || s2_adv_s;
  assign accept_s  = in_vld && in_rdy;
  assign deliver_s = s2_vld_r && out_rdy;

  // Syndrome and classification of the codeword held in stage 1.
  always_comb begin
    syn_s      = calc_syn(s1_data_r, s1_par_r[5:0]);
    ovr_s      = ^{s1_data_r, s1_par_r};
    cor_data_s = s1_data_r;
    ce_s       = 1'b0;
    ue_s       = 1'b0;
    if (!ovr_s) begin
      ue_s = (syn_s != 6'd0);
    end else if ((syn_s == 6'd0) || is_pow2(syn_s)) begin
      ce_s = 1'b1;
    end else if (syn_s <= 6'd38) begin
      ce_s       = 1'b1;
      cor_data_s = flip_at(s1_data_r, syn_s);
    end else begin
      ue_s = 1'b1;
    end
  end

  // Pipeline valid bits and payload; stage 2 freezes while its result is stalled.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s1_vld_r  <= 1'b0;
      s1_data_r <= 32'd0;
      s1_par_r  <= 7'd0;
      s2_vld_r  <= 1'b0;
      s2_data_r <= 32'd0;
      s2_ce_r   <= 1'b0;
      s2_ue_r   <= 1'b0;
      s2_syn_r  <= 6'd0;
    end else begin
      if (in_rdy) s1_vld_r <= in_vld;
      if (accept_s) begin
        s1_data_r <= in_data;
        s1_par_r  <= in_par;
      end
      if (s2_adv_s) s2_vld_r <= s1_vld_r;
      if (s2_adv_s && s1_vld_r) begin
        s2_data_r <= cor_data_s;
        s2_ce_r   <= ce_s;
        s2_ue_r   <= ue_s;
        s2_syn_r  <= syn_s;
      end
    end
  end

  // Saturating error counters and first-error log; a held UE entry is sticky.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      ce_cnt_r  <= 8'd0;
      ue_cnt_r  <= 8'd0;
      log_vld_r <= 1'b0;
      log_ue_r  <= 1'b0;
      log_syn_r <= 6'd0;
    end else if (cnt_clr) begin
      ce_cnt_r  <= 8'd0;
      ue_cnt_r  <= 8'd0;
      log_vld_r <= 1'b0;
      log_ue_r  <= 1'b0;
      log_syn_r <= 6'd0;
    end else if (deliver_s) begin
      if (s2_ce_r && (ce_cnt_r != 8'hFF)) ce_cnt_r <= ce_cnt_r + 8'd1;
      if (s2_ue_r && (ue_cnt_r != 8'hFF)) ue_cnt_r <= ue_cnt_r + 8'd1;
      if ((s2_ce_r || s2_ue_r) && (!log_vld_r || (s2_ue_r && !log_ue_r))) begin
        log_vld_r <= 1'b1;
        log_ue_r  <= s2_ue_r;
        log_syn_r <= s2_syn_r;
      end
    end
  end

  assign out_vld  = s2_vld_r;
  assign out_data = s2_data_r;
  assign out_ce   = s2_ce_r;
  assign out_ue   = s2_ue_r;
  assign out_syn  = s2_syn_r;
  assign ce_cnt   = ce_cnt_r;
  assign ue_cnt   = ue_cnt_r;
  assign log_vld  = log_vld_r;
  assign log_ue   = log_ue_r;
  assign log_syn  = log_syn_r;

endmodule

// File: tb/tb_zzecc_sctag_cor_pipe.sv
// Bench for zzecc_sctag_cor_pipe: directed vectors plus random codewords scored against a
// positional Hamming reference model, with a queue-based pipeline/handshake model.
module tb_zzecc_sctag_cor_pipe;

  logic        rclk = 1'b0;
  logic        arst_l, in_vld, in_rdy, out_vld, out_rdy, out_ce, out_ue, cnt_clr;
  logic        log_vld, log_ue;
  logic [31:0] in_data, out_data;
  logic [6:0]  in_par;
  logic [5:0]  out_syn, log_syn;
  logic [7:0]  ce_cnt, ue_cnt;

  zzecc_sctag_cor_pipe dut (
    .rclk(rclk), .arst_l(arst_l), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_data(in_data), .in_par(in_par), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
    .log_vld(log_vld), .log_ue(log_ue), .log_syn(log_syn)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [31:0] data;
    logic        ce;
    logic        ue;
    logic [5:0]  syn;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic acc_flag;
  logic [7:0] m_ce, m_ue;
  logic       m_lv, m_lu;
  logic [5:0] m_ls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Place data into the 38 code positions (power-of-two slots reserved for parity).
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  p;
    int j;
    cw = '0;
    j = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ($countones(pos) != 1) begin cw[pos] = d[j]; j++; end
    for (int k = 0; k < 6; k++) begin
      p[k] = 1'b0;
      for (int pos = 1; pos <= 38; pos++) if (pos[k]) p[k] = p[k] ^ cw[pos];
    end
    for (int k = 0; k < 6; k++) cw[1 << k] = p[k];
    p[6] = ^cw;
    return p;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] d, input logic [6:0] par);
    logic [38:0] cw;
    logic [5:0]  syn;
    exp_t r;
    int j;
    cw = '0;
    cw[0] = par[6];
    for (int k = 0; k < 6; k++) cw[1 << k] = par[k];
    j = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ($countones(pos) != 1) begin cw[pos] = d[j]; j++; end
    syn = 6'd0;
    for (int pos = 1; pos <= 38; pos++) if (cw[pos]) syn = syn ^ 6'(pos);
    r.data = d; r.ce = 1'b0; r.ue = 1'b0; r.syn = syn; r.acc = 0;
    if (!(^cw)) r.ue = (syn != 6'd0);
    else if (syn <= 6'd38) begin
      r.ce = 1'b1;
      cw[syn] = ~cw[syn];
      j = 0;
      for (int pos = 1; pos <= 38; pos++)
        if ($countones(pos) != 1) begin r.data[j] = cw[pos]; j++; end
    end else r.ue = 1'b1;
    return r;
  endfunction

  // kind: 0 clean, 1 any single flip, 2 double flip, 3 junk parity, 4 single data flip
  task automatic gen_rand(input int kind);
    logic [38:0] w;
    int a, b;
    w[38:7] = $urandom;
    w[6:0]  = enc(w[38:7]);
    case (kind)
      1: w = w ^ (39'd1 << $urandom_range(0, 38));
      2: begin
        a = $urandom_range(0, 38);
        b = (a + $urandom_range(1, 38)) % 39;
        w = w ^ (39'd1 << a) ^ (39'd1 << b);
      end
      3: w[6:0] = 7'($urandom);
      4: w = w ^ (39'd1 << (7 + $urandom_range(0, 31)));
      default: ;
    endcase
    in_data = w[38:7];
    in_par  = w[6:0];
    nxt = ref_dec(in_data, in_par);
  endtask

  function automatic logic exp_vld();
    return (q.size() > 0) && (cyc >= q[0].acc + 2);
  endfunction

  // Check the current cycle against the model, then advance model and clock together.
  task automatic tick();
    logic ev, er;
    exp_t f;
    #1;
    ev = exp_vld();
    er = !((q.size() == 2) && !out_rdy);
    chk("out_vld", 32'(out_vld), 32'(ev));
    chk("in_rdy", 32'(in_rdy), 32'(er));
    if (ev) begin
      chk("out_data", out_data, q[0].data);
      chk("out_ce", 32'(out_ce), 32'(q[0].ce));
      chk("out_ue", 32'(out_ue), 32'(q[0].ue));
      chk("out_syn", 32'(out_syn), 32'(q[0].syn));
    end
    chk("ce_cnt", 32'(ce_cnt), 32'(m_ce));
    chk("ue_cnt", 32'(ue_cnt), 32'(m_ue));
    chk("log_vld", 32'(log_vld), 32'(m_lv));
    chk("log_ue", 32'(log_ue), 32'(m_lu));
    chk("log_syn", 32'(log_syn), 32'(m_ls));
    if (cnt_clr) begin
      m_ce = 8'd0; m_ue = 8'd0; m_lv = 1'b0; m_lu = 1'b0; m_ls = 6'd0;
    end
    if (ev && out_rdy) begin
      f = q.pop_front();
      if (!cnt_clr) begin
        if (f.ce && m_ce != 8'hFF) m_ce = m_ce + 8'd1;
        if (f.ue && m_ue != 8'hFF) m_ue = m_ue + 8'd1;
        if ((f.ce || f.ue) && (!m_lv || (f.ue && !m_lu))) begin
          m_lv = 1'b1; m_lu = f.ue; m_ls = f.syn;
        end
      end
    end
    acc_flag = in_vld && er;
    if (acc_flag) begin
      nxt.acc = cyc;
      q.push_back(nxt);
    end
    @(posedge rclk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_vld = 1'b0; out_rdy = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick();
  endtask

  task automatic send_dir(input logic [31:0] d, input logic [6:0] p, input logic [31:0] ed,
                          input logic ece, input logic eue, input logic [5:0] esyn);
    in_data = d; in_par = p;
    nxt.data = ed; nxt.ce = ece; nxt.ue = eue; nxt.syn = esyn; nxt.acc = 0;
    in_vld = 1'b1; out_rdy = 1'b1; cnt_clr = 1'b0;
    tick();
    drain();
  endtask

  initial begin
    int sent;
    arst_l = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; cnt_clr = 1'b0;
    in_data = 32'd0; in_par = 7'd0;
    m_ce = 8'd0; m_ue = 8'd0; m_lv = 1'b0; m_lu = 1'b0; m_ls = 6'd0;
    #3;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {30'd0, out_ce, out_ue}, 32'd0);
    chk("rst_out_syn", 32'(out_syn), 32'd0);
    chk("rst_cnts", {16'd0, ce_cnt, ue_cnt}, 32'd0);
    chk("rst_log", {25'd0, log_vld, log_ue, log_syn}, 32'd0);
    @(posedge rclk); @(posedge rclk); #1;
    arst_l = 1'b1;

    // Hand-derived vectors
    send_dir(32'h0, 7'h00, 32'h0, 1'b0, 1'b0, 6'd0);
    send_dir(32'h0, 7'h43, 32'h1, 1'b1, 1'b0, 6'd3);
    chk("log_after_ce", {25'd0, log_vld, log_ue, log_syn}, {25'd0, 1'b1, 1'b0, 6'd3});
    send_dir(32'h0, 7'h06, 32'h0, 1'b0, 1'b1, 6'd6);
    chk("log_after_ue", {25'd0, log_vld, log_ue, log_syn}, {25'd0, 1'b1, 1'b1, 6'd6});
    send_dir(32'h0, 7'h40, 32'h0, 1'b1, 1'b0, 6'd0);
    send_dir(32'h0, 7'h7F, 32'h0, 1'b0, 1'b1, 6'd63);
    chk("log_ue_sticky", 32'(log_syn), 32'd6);

    // Backpressure: out_rdy 1,0,0,1 repeating while streaming 5 words
    sent = 0;
    gen_rand(1);
    in_vld = 1'b1;
    for (int t = 0; t < 40 && sent < 5; t++) begin
      out_rdy = (t % 4 == 0) || (t % 4 == 3);
      tick();
      if (acc_flag) begin sent++; gen_rand(1); end
    end
    chk("bp_sent", 32'(sent), 32'd5);
    drain();

    // Random traffic with random backpressure and occasional clears
    for (int t = 0; t < 250; t++) begin
      gen_rand($urandom_range(0, 3));
      in_vld  = ($urandom_range(0, 1) == 1);
      out_rdy = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    drain();

    // Saturation with 300 correctable words
    in_vld = 1'b1; out_rdy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      gen_rand(4);
      tick();
    end
    drain();
    chk("ce_sat", 32'(ce_cnt), 32'hFF);

    // Clear coinciding with a CE delivery
    gen_rand(4);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    for (int t = 0; t < 10 && q.size() > 0; t++) begin
      cnt_clr = exp_vld();
      tick();
    end
    cnt_clr = 1'b0;
    tick();
    chk("clr_ce_cnt", 32'(ce_cnt), 32'd0);
    chk("clr_log_vld", 32'(log_vld), 32'd0);

    // Reset with two words in flight
    in_vld = 1'b1;
    gen_rand(1); tick();
    gen_rand(2); tick();
    in_vld = 1'b0;
    #2;
    arst_l = 1'b0;
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    chk("arst_cnts", {16'd0, ce_cnt, ue_cnt}, 32'd0);
    q.delete();
    m_ce = 8'd0; m_ue = 8'd0; m_lv = 1'b0; m_lu = 1'b0; m_ls = 6'd0;
    @(posedge rclk); cyc++; #1;
    arst_l = 1'b1;
    for (int t = 0; t < 5; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zzecc_sctag_cor_pipe.md
# zzecc_sctag_cor_pipe

Two-stage pipelined SEC-DED check/correct stage for 32-bit data protected by the 7-bit sctag Hamming code produced by zzecc_sctag_pgen_32b. It sits directly downstream of the parity generator and storage. It accepts a stored {data, parity} codeword under a valid/ready handshake and computes the syndrome in stage 1. In stage 2 it corrects single-bit errors, flags uncorrectable ones, and keeps saturating error counters plus a first-error log for CSR readout.

## Interface

- No parameters; the data width is fixed at 32 and the parity width at 7.
- rclk  in  1  clock; every flop is clocked on the rising edge.
- arst_l  in  1  asynchronous active-low reset.
- in_vld  in  1  input codeword is valid.
- in_rdy  out  1  the block accepts the codeword this cycle.
- in_data  in  32  received data d[31:0].
- in_par  in  7  received parity; [5:0] = P1, P2, P4, P8, P16, P32; [6] = overall parity.
- out_vld  out  1  result is valid.
- out_rdy  in  1  the consumer accepts the result.
- out_data  out  32  corrected data.
- out_ce  out  1  a single-bit error was corrected, or a parity-only error was detected.
- out_ue  out  1  uncorrectable error; out_data is the raw in_data.
- out_syn  out  6  syndrome of the result.
- cnt_clr  in  1  synchronous clear of the counters and the log.
- ce_cnt  out  8  saturating count of CE results delivered.
- ue_cnt  out  8  saturating count of UE results delivered.
- log_vld  out  1  the error log holds an entry.
- log_ue  out  1  the logged entry is a UE.
- log_syn  out  6  syndrome of the logged entry.

## Operation

- Code layout: 38-position Hamming code.
  - Parity bits sit at positions 1, 2, 4, 8, 16, 32.
  - d0..d31 fill the remaining positions 3..38 in ascending order (d0@3, d1@5, d2@6, d3@7, d4@9, ..., d11@17, ..., d26@33, ..., d31@38).
  - in_par[6] is the XOR of all 38 bits, so the 39-bit word has even parity.
- Stage 1 (S1) registers the data and the parity, then computes:
  - syn[k] = in_par[k] XOR (XOR of every data bit whose position has bit k set), for k = 0..5.
  - ovr = XOR of all 32 data bits and all 7 parity bits.
- Stage 2 (S2) registers the data, syn and ovr, then classifies:
  - syn=0, ovr=0: clean. ce=0, ue=0.
  - ovr=1, syn=0: the error is in P[6]. ce=1 and the data is unchanged.
  - ovr=1, syn is a power of two: the error is in a parity bit. ce=1 and the data is unchanged.
  - ovr=1, syn in 3..38 and not a power of two: the data bit at that position is flipped. ce=1.
  - ovr=1, syn in 39..63: ue=1 and the data passes raw.
  - ovr=0, syn≠0: double error. ue=1 and the data passes raw.
  - ce and ue are never both 1.
- Counters:
  - Each counter increments by 1 when out_vld&&out_rdy and the matching flag is set.
  - Both counters saturate at 0xFF.
  - cnt_clr takes priority over an increment in the same cycle; the result is 0.
- Log:
  - On the first delivered CE or UE while log_vld=0, capture {log_ue, log_syn} and set log_vld.
  - A delivered UE overwrites a held CE entry.
  - A held UE entry is never overwritten.
  - cnt_clr clears log_vld, log_ue and log_syn, and wins over a capture in the same cycle.

## Timing

- Reset (async, arst_l=0):
  - S1 and S2 valid bits are 0, so out_vld=0 and in_rdy=1.
  - out_data, out_syn, out_ce and out_ue are 0.
  - Counters are 0. log_vld, log_ue and log_syn are 0.
- Reset asserted mid-operation discards every in-flight codeword. Nothing is delivered after release.
- Latency: a codeword accepted in cycle N appears on out_vld in cycle N+2 if no stall occurs.
- Throughput: one codeword per cycle.
- Stall handling:
  - S2 holds while out_vld&&!out_rdy. All outputs stay stable while held.
  - S1 advances when S2 is empty or S2 is being drained.
  - in_rdy = !s1_vld || s1_adv. in_rdy is combinational from out_rdy; there is no skid buffer.
- Simultaneous accept and deliver in the same cycle is permitted at both ends.
- Data payload flops have no reset requirement beyond the reset values listed above.

## Test plan

- Clean word: data 0x00000000, par 0x00, out_rdy=1 → 2 cycles later out_vld=1, data 0x00000000, ce=0, ue=0, syn=0.
- Single data error: data 0x00000000, par 0x43 (the codeword for 0x00000001 with d0 flipped) → out_data 0x00000001, ce=1, syn=3. Then ce_cnt=1, log_vld=1, log_ue=0, log_syn=3.
- Double error: data 0x00000000, par 0x06 (the codeword for 0x00000003 with d0 and d1 flipped) → ue=1, out_data 0x00000000, syn=6. Then ue_cnt=1, and the log changes from CE to UE.
- Parity and out-of-range errors:
  - par 0x40 with data 0 → ce=1, syn=0, data unchanged.
  - par 0x7F with data 0 → syn=63, ovr=1, ue=1.
- Backpressure: stream 5 words with out_rdy toggling 1,0,0,1,... → no loss or duplication, order preserved, outputs stable while stalled, in_rdy=0 exactly when both stages are full and S2 is stalled.
- Saturation, clear and reset:
  - Feed 300 CE words → ce_cnt=0xFF.
  - cnt_clr together with a CE delivery → ce_cnt=0 and log_vld=0.
  - arst_l pulsed with 2 words in flight → out_vld=0 immediately, and no output after release.
